// File: rtl/cpu_pkg.sv
// Shared definitions for the 5-stage MIPS core: ALU op encodings and the
// control bundle that travels from ID into EX.
package cpu_pkg;

    localparam int ALU_OP_W = 3;

    // ALU op classes decoded by the EX-stage ALU control
    localparam logic [ALU_OP_W-1:0] ALU_OP_NOP   = 3'b000;
    localparam logic [ALU_OP_W-1:0] ALU_OP_ADD   = 3'b001;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SUB   = 3'b010;
    localparam logic [ALU_OP_W-1:0] ALU_OP_RTYPE = 3'b011;
    localparam logic [ALU_OP_W-1:0] ALU_OP_AND   = 3'b100;
    localparam logic [ALU_OP_W-1:0] ALU_OP_OR    = 3'b101;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SLT   = 3'b110;
    localparam logic [ALU_OP_W-1:0] ALU_OP_LUI   = 3'b111;

    typedef struct packed {
        logic                reg_dst;
        logic                alu_src;
        logic [ALU_OP_W-1:0] alu_op;
        logic                mem_read;
        logic                mem_write;
        logic                reg_write;
        logic                mem_to_reg;
        logic                jump;
    } ctrl_ex_t;

    localparam int CTRL_W = $bits(ctrl_ex_t);

    // A bubble has no architectural effect: no writes, ALU op is NOP
    localparam ctrl_ex_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_pipeline_reg_pipe_field_reg.sv
// Generic pipeline field register with reset > flush > hold > load priority.
// CLR_ON_FLUSH selects whether a flush zeroes the field (control) or leaves
// it stale (datapath, qualified downstream by the valid bit).
module pipe_field_reg #(
    parameter int W            = 32,
    parameter bit CLR_ON_FLUSH = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         hold,
    input  logic         flush,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Prioritised update: reset, then flush, then hold, else load
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (flush) begin
            if (CLR_ON_FLUSH)
                q <= '0;
        end else if (!hold) begin
            q <= d;
        end
    end

endmodule

// File: rtl/id_ex_pipeline_reg.sv
// ID/EX pipeline register. Control bundle plus valid bit clear on flush;
// datapath fields keep stale values on flush.
// Optional macro ID_EX_PERF_CNT_EN adds bubble_cnt / flush_cnt counters.
module id_ex_pipeline_reg
    import cpu_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  hold,
    input  logic                  flush,
    input  logic                  id_valid,
    input  logic                  reg_dst_in,
    input  logic                  alu_src_in,
    input  logic                  mem_read_in,
    input  logic                  mem_write_in,
    input  logic                  reg_write_in,
    input  logic                  mem_to_reg_in,
    input  logic                  jump_in,
    input  logic [ALU_OP_W-1:0]   alu_op_in,
    input  logic [DATA_W-1:0]     pc_plus4_in,
    input  logic [DATA_W-1:0]     rd1_in,
    input  logic [DATA_W-1:0]     rd2_in,
    input  logic [DATA_W-1:0]     imm_in,
    input  logic [REG_ADDR_W-1:0] rs_in,
    input  logic [REG_ADDR_W-1:0] rt_in,
    input  logic [REG_ADDR_W-1:0] rd_in,
    output logic                  reg_dst_out,
    output logic                  alu_src_out,
    output logic                  mem_read_out,
    output logic                  mem_write_out,
    output logic                  reg_write_out,
    output logic                  mem_to_reg_out,
    output logic                  jump_out,
    output logic [ALU_OP_W-1:0]   alu_op_out,
    output logic [DATA_W-1:0]     pc_plus4_out,
    output logic [DATA_W-1:0]     rd1_out,
    output logic [DATA_W-1:0]     rd2_out,
    output logic [DATA_W-1:0]     imm_out,
    output logic [REG_ADDR_W-1:0] rs_out,
    output logic [REG_ADDR_W-1:0] rt_out,
    output logic [REG_ADDR_W-1:0] rd_out,
    output logic                  ex_valid
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [31:0]           bubble_cnt,
    output logic [31:0]           flush_cnt
`endif
);

    localparam int DP_W = 4*DATA_W + 3*REG_ADDR_W;

    ctrl_ex_t        ctrl_in;
    ctrl_ex_t        ctrl_ld;
    ctrl_ex_t        ctrl_q;
    logic [CTRL_W:0] ctrl_vq;
    logic [DP_W-1:0] dp_d;
    logic [DP_W-1:0] dp_q;

    assign ctrl_in = '{reg_dst:    reg_dst_in,
                       alu_src:    alu_src_in,
                       alu_op:     alu_op_in,
                       mem_read:   mem_read_in,
                       mem_write:  mem_write_in,
                       reg_write:  reg_write_in,
                       mem_to_reg: mem_to_reg_in,
                       jump:       jump_in};

    // An invalid ID slot must never carry live controls into EX
    assign ctrl_ld = id_valid ? ctrl_in : CTRL_BUBBLE;

    // Valid bit rides with the control bundle so a flush kills both together
    pipe_field_reg #(.W(CTRL_W + 1), .CLR_ON_FLUSH(1'b1)) u_ctrl (
        .clk   (clk),
        .reset (reset),
        .hold  (hold),
        .flush (flush),
        .d     ({ctrl_ld, id_valid}),
        .q     (ctrl_vq)
    );

    assign dp_d = {pc_plus4_in, rd1_in, rd2_in, imm_in, rs_in, rt_in, rd_in};

    pipe_field_reg #(.W(DP_W), .CLR_ON_FLUSH(1'b0)) u_data (
        .clk   (clk),
        .reset (reset),
        .hold  (hold),
        .flush (flush),
        .d     (dp_d),
        .q     (dp_q)
    );

    assign ctrl_q         = ctrl_vq[CTRL_W:1];
    assign ex_valid       = ctrl_vq[0];
    assign reg_dst_out    = ctrl_q.reg_dst;
    assign alu_src_out    = ctrl_q.alu_src;
    assign alu_op_out     = ctrl_q.alu_op;
    assign mem_read_out   = ctrl_q.mem_read;
    assign mem_write_out  = ctrl_q.mem_write;
    assign reg_write_out  = ctrl_q.reg_write;
    assign mem_to_reg_out = ctrl_q.mem_to_reg;
    assign jump_out       = ctrl_q.jump;
    assign {pc_plus4_out, rd1_out, rd2_out, imm_out, rs_out, rt_out, rd_out} = dp_q;

`ifdef ID_EX_PERF_CNT_EN
    // Count flushes, and normal loads that carry a bubble or an empty slot
    always_ff @(posedge clk) begin
        if (reset) begin
            bubble_cnt <= '0;
            flush_cnt  <= '0;
        end else if (flush) begin
            flush_cnt <= flush_cnt + 32'd1;
        end else if (!hold && (!id_valid || ctrl_in == CTRL_BUBBLE)) begin
            bubble_cnt <= bubble_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// Scoreboard bench for id_ex_pipeline_reg: the driver pushes the expected
// EX-side contents per edge, a monitor pops and compares after each edge.
module tb_id_ex_pipeline_reg;
    import cpu_pkg::*;

    typedef struct packed {
        ctrl_ex_t    ctrl;
        logic [31:0] pc, rd1, rd2, imm;
        logic [4:0]  rs, rt, rd;
    } fields_t;

    typedef struct {
        fields_t f;
        logic    v;
        bit      chk_data;
        int      tag;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   step   = 0;

    logic clk = 1'b0;
    logic reset, hold, flush, id_valid;
    logic reg_dst_in, alu_src_in, mem_read_in, mem_write_in, reg_write_in, mem_to_reg_in, jump_in;
    logic [2:0]  alu_op_in;
    logic [31:0] pc_plus4_in, rd1_in, rd2_in, imm_in;
    logic [4:0]  rs_in, rt_in, rd_in;
    logic reg_dst_out, alu_src_out, mem_read_out, mem_write_out, reg_write_out, mem_to_reg_out, jump_out;
    logic [2:0]  alu_op_out;
    logic [31:0] pc_plus4_out, rd1_out, rd2_out, imm_out;
    logic [4:0]  rs_out, rt_out, rd_out;
    logic        ex_valid;
`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] bubble_cnt, flush_cnt;
`endif

    always #5 clk = ~clk;

    id_ex_pipeline_reg dut (
        .clk(clk), .reset(reset), .hold(hold), .flush(flush), .id_valid(id_valid),
        .reg_dst_in(reg_dst_in), .alu_src_in(alu_src_in), .mem_read_in(mem_read_in),
        .mem_write_in(mem_write_in), .reg_write_in(reg_write_in),
        .mem_to_reg_in(mem_to_reg_in), .jump_in(jump_in), .alu_op_in(alu_op_in),
        .pc_plus4_in(pc_plus4_in), .rd1_in(rd1_in), .rd2_in(rd2_in), .imm_in(imm_in),
        .rs_in(rs_in), .rt_in(rt_in), .rd_in(rd_in),
        .reg_dst_out(reg_dst_out), .alu_src_out(alu_src_out), .mem_read_out(mem_read_out),
        .mem_write_out(mem_write_out), .reg_write_out(reg_write_out),
        .mem_to_reg_out(mem_to_reg_out), .jump_out(jump_out), .alu_op_out(alu_op_out),
        .pc_plus4_out(pc_plus4_out), .rd1_out(rd1_out), .rd2_out(rd2_out), .imm_out(imm_out),
        .rs_out(rs_out), .rt_out(rt_out), .rd_out(rd_out),
        .ex_valid(ex_valid)
`ifdef ID_EX_PERF_CNT_EN
        , .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
`endif
    );

    fields_t act;
    always_comb begin
        act = '0;
        act.ctrl = '{reg_dst: reg_dst_out, alu_src: alu_src_out, alu_op: alu_op_out,
                     mem_read: mem_read_out, mem_write: mem_write_out,
                     reg_write: reg_write_out, mem_to_reg: mem_to_reg_out, jump: jump_out};
        act.pc  = pc_plus4_out;
        act.rd1 = rd1_out;
        act.rd2 = rd2_out;
        act.imm = imm_out;
        act.rs  = rs_out;
        act.rt  = rt_out;
        act.rd  = rd_out;
    end

    // Monitor: one expectation per edge, compared 1 time unit after the edge
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            checks++;
            if (act.ctrl !== mon_e.f.ctrl || ex_valid !== mon_e.v ||
                (mon_e.chk_data && act[142:0] !== mon_e.f[142:0])) begin
                errors++;
                $display("FAIL step%0d: got ctrl=%h v=%b data=%h, want ctrl=%h v=%b data=%h (data checked=%0d)",
                         mon_e.tag, act.ctrl, ex_valid, act[142:0],
                         mon_e.f.ctrl, mon_e.v, mon_e.f[142:0], mon_e.chk_data);
            end
        end
    end

    task automatic drive(input logic r, input logic h, input logic fl, input logic idv,
                         input fields_t f, input logic ev, input fields_t ef, input bit cd);
        exp_t e;
        @(negedge clk);
        reset = r; hold = h; flush = fl; id_valid = idv;
        reg_dst_in = f.ctrl.reg_dst;     alu_src_in = f.ctrl.alu_src;
        alu_op_in = f.ctrl.alu_op;       mem_read_in = f.ctrl.mem_read;
        mem_write_in = f.ctrl.mem_write; reg_write_in = f.ctrl.reg_write;
        mem_to_reg_in = f.ctrl.mem_to_reg; jump_in = f.ctrl.jump;
        pc_plus4_in = f.pc; rd1_in = f.rd1; rd2_in = f.rd2; imm_in = f.imm;
        rs_in = f.rs; rt_in = f.rt; rd_in = f.rd;
        e.f = ef; e.v = ev; e.chk_data = cd; e.tag = step;
        sb.push_back(e);
        step++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got running, want finished");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    fields_t ZERO, ONES, F1, F2, F2B, FA, F5, FJ;

    initial begin
        ZERO = '0;
        ONES = '1;
        reset = 1'b1; hold = 1'b1; flush = 1'b1; id_valid = 1'b1;
        reg_dst_in = 1'b1; alu_src_in = 1'b1; mem_read_in = 1'b1; mem_write_in = 1'b1;
        reg_write_in = 1'b1; mem_to_reg_in = 1'b1; jump_in = 1'b1; alu_op_in = 3'b111;
        pc_plus4_in = '1; rd1_in = '1; rd2_in = '1; imm_in = '1;
        rs_in = '1; rt_in = '1; rd_in = '1;

        F1 = ZERO; F1.rd1 = 32'h1234;
        F2 = ZERO; F2.ctrl.reg_write = 1'b1; F2.ctrl.alu_op = 3'b010; F2.rt = 5'd9;
        F2.pc = 32'h40; F2.imm = 32'hFFFF_FFF0;
        F2B = F2; F2B.ctrl = CTRL_BUBBLE;
        FA = ZERO; FA.ctrl.mem_write = 1'b1; FA.ctrl.reg_write = 1'b1; FA.ctrl.alu_src = 1'b1;
        FA.rd1 = 32'hAAAA; FA.rs = 5'd3; FA.pc = 32'h100; FA.rd2 = 32'hDEAD_BEEF;
        F5 = ZERO; F5.ctrl.reg_write = 1'b1; F5.ctrl.mem_read = 1'b1; F5.ctrl.mem_to_reg = 1'b1;
        F5.rd1 = 32'h5555; F5.pc = 32'h104; F5.rd = 5'd31;
        FJ = ZERO; FJ.ctrl.jump = 1'b1; FJ.ctrl.reg_dst = 1'b1; FJ.ctrl.alu_op = 3'b101;
        FJ.pc = 32'h200; FJ.rd = 5'd17;

        // Reset with every input high, even hold and flush
        drive(1, 1, 1, 1, ONES, 0, ZERO, 1);
        drive(1, 1, 1, 1, ONES, 0, ZERO, 1);
        // First load after reset
        drive(0, 0, 0, 1, F1, 1, F1, 1);
        drive(0, 0, 0, 1, F2, 1, F2, 1);
        // Hold three cycles with new inputs, then release
        drive(0, 0, 0, 1, FA, 1, FA, 1);
        drive(0, 1, 0, 1, F5, 1, FA, 1);
        drive(0, 1, 0, 1, F5, 1, FA, 1);
        drive(0, 1, 0, 1, F5, 1, FA, 1);
        drive(0, 0, 0, 1, F5, 1, F5, 1);
        // Flush beats hold; data may be stale so only controls/valid are checked
        drive(0, 0, 0, 1, FA, 1, FA, 1);
        drive(0, 1, 1, 1, F5, 0, ZERO, 0);
        // Invalid ID slot: data loads, controls forced off
        drive(0, 0, 0, 0, F2, 0, F2B, 1);
        // Hazard bubble: controls already zero, still a valid load
        drive(0, 0, 0, 1, F2B, 1, F2B, 1);
        // Reset during hold clears, next normal edge loads fresh
        drive(0, 0, 0, 1, F2, 1, F2, 1);
        drive(1, 1, 0, 1, F5, 0, ZERO, 1);
        drive(0, 0, 0, 1, F1, 1, F1, 1);
        // Flush alone, then a jump entry
        drive(0, 0, 0, 1, FA, 1, FA, 1);
        drive(0, 0, 1, 1, F5, 0, ZERO, 0);
        drive(0, 0, 0, 1, FJ, 1, FJ, 1);
        drive(0, 1, 0, 0, F2, 1, FJ, 1);

`ifdef ID_EX_PERF_CNT_EN
        // 2 hazard bubbles, 1 flush, 3 hold-only cycles
        drive(1, 0, 0, 1, F1, 0, ZERO, 1);
        drive(0, 0, 0, 1, F1, 1, F1, 1);
        drive(0, 0, 0, 1, F1, 1, F1, 1);
        drive(0, 0, 1, 1, F5, 0, ZERO, 0);
        drive(0, 1, 0, 1, F5, 0, ZERO, 0);
        drive(0, 1, 0, 1, F5, 0, ZERO, 0);
        drive(0, 1, 0, 1, F5, 0, ZERO, 0);
        @(posedge clk);
        #2;
        checks++;
        if (bubble_cnt !== 32'd2) begin
            errors++;
            $display("FAIL bubble_cnt: got %0d want 2", bubble_cnt);
        end
        checks++;
        if (flush_cnt !== 32'd1) begin
            errors++;
            $display("FAIL flush_cnt: got %0d want 1", flush_cnt);
        end
`endif

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
